bcd_x3_scheduler: RTL and testbench

Time-shares a single serial BCD-to-Excess-3 converter (Mealy machine, LSB-first, 4-bit groups) between two parallel requesters. Each accepted BCD digit is serialized into the converter, and the serial Excess-3 output is reassembled. The parallel result is returned with the requester's ID. The block sits between the digit producers and the converter instance and owns the converter's `x_in` and reset.

---
 rtl/bcd_x3_pkg.sv | 14 +
 rtl/bcd_x3_scheduler_rr_arb2.sv | 23 ++
 rtl/bcd_x3_scheduler.sv | 151 +++++++++++++++
 tb/tb_bcd_x3_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_x3_pkg.sv
// Shared types and constants for the BCD to Excess-3 converter scheduler.
package bcd_x3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned BCD_W     = 4;
    localparam int unsigned BCD_MAX   = 9;
    localparam int unsigned X3_OFFSET = 3;

endpackage

// File: rtl/bcd_x3_scheduler_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on a tie the requester that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       gnt_id
);

    always_comb begin
        gnt_id = 1'b0;
        grant  = 2'b00;
        case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last_grant;
            default: gnt_id = 1'b0;
        endcase
        if (req != 2'b00) begin
            grant = gnt_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/bcd_x3_scheduler.sv
// bcd_x3_scheduler: time-shares one serial LSB-first BCD->Excess-3 Mealy converter between two requesters.
// Optional feature: define BCD_X3_CHECK_EN to reject digits above 9 with a one-cycle res_err pulse.
module bcd_x3_scheduler
    import bcd_x3_pkg::*;
#(
    parameter int unsigned N_BITS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [BCD_W-1:0] digit0,
    input  logic [BCD_W-1:0] digit1,
    output logic             ack0,
    output logic             ack1,
    output logic             conv_x,
    input  logic             conv_y,
    output logic             conv_rst_n,
    output logic             busy,
    output logic             res_valid,
    output logic [BCD_W-1:0] res_data,
    output logic             res_id
`ifdef BCD_X3_CHECK_EN
    ,
    output logic             res_err
`endif
);

    localparam int unsigned      CNT_W    = $clog2(N_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);
`ifdef BCD_X3_CHECK_EN
    localparam logic [BCD_W-1:0] MAX_DIGIT = BCD_W'(BCD_MAX);
`endif

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BCD_W-1:0]   sr_q;
    logic [BCD_W-1:0]   rsr_q;
    logic [BCD_W-1:0]   rsr_d;
    logic               last_grant_q;
    logic               ack0_q;
    logic               ack1_q;
    logic               conv_rst_n_q;
    logic               busy_q;
    logic               res_valid_q;
    logic [BCD_W-1:0]   res_data_q;
    logic               res_id_q;
`ifdef BCD_X3_CHECK_EN
    logic               res_err_q;
`endif

    logic [1:0]         grant;
    logic               gnt_id;
    logic [BCD_W-1:0]   digit_sel;

    rr_arb2 u_arb (
        .req        ({req1, req0}),
        .last_grant (last_grant_q),
        .grant      (grant),
        .gnt_id     (gnt_id)
    );

    assign digit_sel = gnt_id ? digit1 : digit0;
    // Converter output is Mealy: each sampled Y enters at the MSB so bit i ends up holding cycle i.
    assign rsr_d     = {conv_y, rsr_q[BCD_W-1:1]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            rsr_q        <= '0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            conv_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
`ifdef BCD_X3_CHECK_EN
            res_err_q    <= 1'b0;
`endif
        end else begin
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            res_valid_q <= 1'b0;
`ifdef BCD_X3_CHECK_EN
            res_err_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (grant != 2'b00) begin
                        ack0_q       <= grant[0];
                        ack1_q       <= grant[1];
                        last_grant_q <= gnt_id;
                        res_id_q     <= gnt_id;
                        sr_q         <= digit_sel;
                        busy_q       <= 1'b1;
`ifdef BCD_X3_CHECK_EN
                        // Invalid digits bypass the converter entirely; it stays in reset.
                        if (digit_sel > MAX_DIGIT) begin
                            state_q    <= DONE;
                            res_err_q  <= 1'b1;
                            res_data_q <= '0;
                        end else
`endif
                        begin
                            state_q      <= SHIFT;
                            cnt_q        <= '0;
                            conv_rst_n_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_q >> 1;
                    rsr_q <= rsr_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q      <= DONE;
                        conv_rst_n_q <= 1'b0;
                        res_valid_q  <= 1'b1;
                        res_data_q   <= rsr_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    conv_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign conv_x     = sr_q[0] & conv_rst_n_q;
    assign conv_rst_n = conv_rst_n_q;
    assign busy       = busy_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_id     = res_id_q;
`ifdef BCD_X3_CHECK_EN
    assign res_err    = res_err_q;
`endif

endmodule

// File: tb/tb_bcd_x3_scheduler.sv
// Self-checking bench for bcd_x3_scheduler with a behavioural serial Excess-3 converter and a result scoreboard.
module tb_bcd_x3_scheduler;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       req0   = 1'b0;
    logic       req1   = 1'b0;
    logic [3:0] digit0 = '0;
    logic [3:0] digit1 = '0;
    logic       ack0, ack1, conv_x, conv_y, conv_rst_n, busy, res_valid, res_id;
    logic [3:0] res_data;
    logic       res_err;
`ifndef BCD_X3_CHECK_EN
    assign res_err = 1'b0;
`endif

    bcd_x3_scheduler #(.N_BITS(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .digit0     (digit0),
        .digit1     (digit1),
        .ack0       (ack0),
        .ack1       (ack1),
        .conv_x     (conv_x),
        .conv_y     (conv_y),
        .conv_rst_n (conv_rst_n),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id)
`ifdef BCD_X3_CHECK_EN
        ,
        .res_err    (res_err)
`endif
    );

    initial forever #5 clock = ~clock;

    // Serial converter: adds constant 0011 LSB-first; y is combinational in x (Mealy).
    logic [1:0] cv_pos;
    logic       cv_c;
    logic       cv_k;
    assign cv_k   = (cv_pos < 2'd2);
    assign conv_y = conv_x ^ cv_k ^ cv_c;
    always @(posedge clock or negedge conv_rst_n) begin
        if (!conv_rst_n) begin
            cv_pos <= 2'd0;
            cv_c   <= 1'b0;
        end else begin
            cv_pos <= cv_pos + 2'd1;
            cv_c   <= (conv_x & cv_k) | (conv_x & cv_c) | (cv_k & cv_c);
        end
    end

    typedef struct packed {
        logic        id;
        logic        err;
        logic        chk_data;
        logic [3:0]  data;
        logic [31:0] due;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  dq0[$];
    logic [3:0]  dq1[$];
    logic        gnt_log[$];
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    int unsigned shift_left = 0;
    int unsigned last_res_cyc = 0;
    bit          spacing_on = 1'b0;
    logic [3:0]  xv = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        logic       id;
        logic [3:0] dg;
        logic       bad;
        exp_t       e;
        @(negedge clock);
        cyc++;
        if (ack0 || ack1) begin
            check("ack_onehot", 32'(ack0 & ack1), 32'd0);
            id = ack1;
            if ((!id && dq0.size() == 0) || (id && dq1.size() == 0)) begin
                check("spurious_ack", 32'd1, 32'd0);
            end else begin
                dg = id ? dq1.pop_front() : dq0.pop_front();
                gnt_log.push_back(id);
                bad = 1'b0;
`ifdef BCD_X3_CHECK_EN
                bad = (dg > 4'd9);
`endif
                e.id       = id;
                e.err      = bad;
                e.chk_data = (dg <= 4'd9) || bad;
                e.data     = bad ? 4'd0 : dg + 4'd3;
                e.due      = bad ? cyc : cyc + 4;
                sb.push_back(e);
                shift_left = bad ? 0 : 4;
                xv         = '0;
            end
        end
        check("conv_rst_n", 32'(conv_rst_n), 32'(shift_left > 0));
        if (shift_left > 0) begin
            xv = {conv_x, xv[3:1]};
            shift_left--;
        end
        if (res_valid || res_err) begin
            if (sb.size() == 0) begin
                check("unexpected_res", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("res_cycle", cyc, e.due);
                check("res_id", 32'(res_id), 32'(e.id));
                check("res_kind", 32'({res_err, res_valid}), e.err ? 32'd2 : 32'd1);
                if (e.chk_data) check("res_data", 32'(res_data), 32'(e.data));
                if (spacing_on && last_res_cyc != 0) check("res_spacing", cyc - last_res_cyc, 32'd6);
                last_res_cyc = cyc;
            end
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
            check("res_missing", cyc, sb[0].due);
            sb.delete(0);
        end
        req0   = (dq0.size() > 0) && !ack0;
        digit0 = (dq0.size() > 0) ? dq0[0] : 4'd0;
        req1   = (dq1.size() > 0) && !ack1;
        digit1 = (dq1.size() > 0) ? dq1[0] : 4'd0;
    endtask

    task automatic drain(input int unsigned max_cyc);
        int unsigned n = 0;
        do begin
            step();
            n++;
        end while ((dq0.size() > 0 || dq1.size() > 0 || sb.size() > 0 || shift_left > 0) && n < max_cyc);
        if (dq0.size() > 0 || dq1.size() > 0 || sb.size() > 0) check("drain_timeout", 32'd1, 32'd0);
        step();
        step();
    endtask

    initial begin
        logic [3:0]  g;
        int unsigned n;
        #3;
        check("rst_ack", 32'({ack0, ack1}), 32'd0);
        check("rst_flags", 32'({res_valid, res_err, busy, conv_x, conv_rst_n}), 32'd0);
        check("rst_res", 32'({res_id, res_data}), 32'd0);
        #9 reset = 1'b1;

        dq0.push_back(4'd5);
        drain(40);
        check("conv_x_seq", 32'(xv), 32'(4'b0101));

        spacing_on   = 1'b1;
        last_res_cyc = 0;
        for (int i = 0; i < 10; i++) dq1.push_back(4'(i));
        drain(120);
        spacing_on = 1'b0;

        gnt_log.delete();
        dq0.push_back(4'd2); dq0.push_back(4'd2);
        dq1.push_back(4'd7); dq1.push_back(4'd7);
        drain(80);
        check("grant_count", gnt_log.size(), 32'd4);
        g = '0;
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) g[i] = gnt_log[i];
        check("grant_order", 32'(g), 32'(4'b1010));

        gnt_log.delete();
        dq0.push_back(4'd9);
        n = 0;
        while (gnt_log.size() == 0 && n < 20) begin
            step();
            n++;
        end
        check("rst_test_ack", gnt_log.size(), 32'd1);
        step();
        step();
        #1 reset = 1'b0;
        sb.delete();
        shift_left = 0;
        #1;
        check("midrst_conv_rst_n", 32'(conv_rst_n), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (3) step();
        #1 reset = 1'b1;
        dq0.push_back(4'd4);
        drain(40);

        dq0.push_back(4'd12);
        drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
